// File: rtl/vm_coin_feeder.sv
`default_nettype none
// ============================================================================
// Module   : vm_coin_feeder
// Purpose  : Turns a payment request (in 5-cent units) into one-cycle
//            nickel (a) / dime (b) pulses for the two-coin vending
//            controller. The controller's same-cycle {y,z} answer is checked
//            against a local shadow of its credit state. y and z events are
//            also counted.
// Ports    : clk, rst_n            - clock, async active-low reset
//            start, amount,        - request handshake (sampled in IDLE)
//            prefer_dime
//            clr_cnt               - sync clear of counters and err
//            y, z                  - controller responses (checked in ISSUE)
//            a, b                  - nickel / dime pulses
//            busy, done            - activity flag, end-of-request pulse
//            err                   - sticky response mismatch
//            prod_cnt, change_cnt  - y / z event counters (wrap)
// Revision : 1.0 - initial release
// ============================================================================
module vm_coin_feeder #(
    parameter int AMT_W   = 4,
    parameter int GAP_CYC = 2,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    input  logic             prefer_dime,
    input  logic             clr_cnt,
    input  logic             y,
    input  logic             z,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] prod_cnt,
    output logic [CNT_W-1:0] change_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [AMT_W-1:0] c_one      = AMT_W'(1);
    localparam logic [AMT_W-1:0] c_two      = AMT_W'(2);
    localparam logic [3:0]       c_gap_last = 4'(GAP_CYC - 1);

    state_t             state_q,      state_d;
    logic [AMT_W-1:0]   remaining_q,  remaining_d;
    logic               pref_dime_q,  pref_dime_d;
    logic [3:0]         gap_cnt_q,    gap_cnt_d;
    logic               shadow_q,     shadow_d;
    logic               err_q,        err_d;
    logic [CNT_W-1:0]   prod_cnt_q,   prod_cnt_d;
    logic [CNT_W-1:0]   change_cnt_q, change_cnt_d;

    logic               use_dime;
    logic [1:0]         exp_yz;
    logic               shadow_next;

    // Coin choice is a pure function of registered state, so a/b fall
    // together with the state register when reset is asserted.
    assign use_dime = pref_dime_q && (remaining_q >= c_two);

    assign a          = (state_q == S_ISSUE) && !use_dime;
    assign b          = (state_q == S_ISSUE) &&  use_dime;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign err        = err_q;
    assign prod_cnt   = prod_cnt_q;
    assign change_cnt = change_cnt_q;

    // Expected controller answer and its next credit for the coin being
    // issued. A dime on zero credit vends without change and leaves credit
    // at zero; every other case besides nickel-on-zero clears the credit.
    always_comb begin
        exp_yz      = 2'b00;
        shadow_next = 1'b0;
        case ({shadow_q, use_dime})
            2'b00:   begin exp_yz = 2'b00; shadow_next = 1'b1; end
            2'b01:   begin exp_yz = 2'b10; shadow_next = 1'b0; end
            2'b10:   begin exp_yz = 2'b10; shadow_next = 1'b0; end
            default: begin exp_yz = 2'b11; shadow_next = 1'b0; end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        pref_dime_d  = pref_dime_q;
        gap_cnt_d    = gap_cnt_q;
        shadow_d     = shadow_q;
        err_d        = err_q;
        prod_cnt_d   = prod_cnt_q;
        change_cnt_d = change_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    remaining_d = amount;
                    pref_dime_d = prefer_dime;
                    state_d     = (amount != '0) ? S_ISSUE : S_DONE;
                end
            end
            S_ISSUE: begin
                remaining_d = remaining_q - (use_dime ? c_two : c_one);
                gap_cnt_d   = 4'd0;
                state_d     = S_GAP;
                // Shadow advances even on mismatch so one bad answer does
                // not cascade into errors on every following coin.
                shadow_d    = shadow_next;
                if ({y, z} != exp_yz) begin
                    err_d = 1'b1;
                end
                if (y) begin
                    prod_cnt_d = prod_cnt_q + 1'b1;
                end
                if (z) begin
                    change_cnt_d = change_cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == c_gap_last) begin
                    state_d = (remaining_q != '0) ? S_ISSUE : S_DONE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Clear wins over any same-cycle increment or error set.
        if (clr_cnt) begin
            prod_cnt_d   = '0;
            change_cnt_d = '0;
            err_d        = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            remaining_q  <= '0;
            pref_dime_q  <= 1'b0;
            gap_cnt_q    <= 4'd0;
            shadow_q     <= 1'b0;
            err_q        <= 1'b0;
            prod_cnt_q   <= '0;
            change_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            pref_dime_q  <= pref_dime_d;
            gap_cnt_q    <= gap_cnt_d;
            shadow_q     <= shadow_d;
            err_q        <= err_d;
            prod_cnt_q   <= prod_cnt_d;
            change_cnt_q <= change_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vm_coin_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_vm_coin_feeder
// Purpose  : Directed bench for vm_coin_feeder. A behavioural two-coin
//            vending controller answers the feeder's coin pulses. Expected
//            values are hand-computed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vm_coin_feeder;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] amount;
    logic       prefer_dime;
    logic       clr_cnt;
    logic       y;
    logic       z;
    logic       a;
    logic       b;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] prod_cnt;
    logic [7:0] change_cnt;

    // Controller model: one bit of credit (0 or 5 cents).
    logic ctl_credit;
    logic force_y0;

    int n_checks = 0;
    int n_err    = 0;

    vm_coin_feeder #(.AMT_W(4), .GAP_CYC(2), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .amount     (amount),
        .prefer_dime(prefer_dime),
        .clr_cnt    (clr_cnt),
        .y          (y),
        .z          (z),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .prod_cnt   (prod_cnt),
        .change_cnt (change_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Nickel vends once 10 cents are reached; a dime always vends, and
    // returns change when 5 cents were already inserted.
    always_comb begin
        y = (a ? ctl_credit : b) & ~force_y0;
        z = b & ctl_credit;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)  ctl_credit <= 1'b0;
        else if (a)  ctl_credit <= ~ctl_credit;
        else if (b)  ctl_credit <= 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request and watches it until done (bounded). Cycle 1 is the
    // cycle after the accepting edge. spam keeps start high throughout.
    task automatic run_req(input logic [3:0] amt, input logic pd, input logic spam,
                           output int na, output int nb, output int dcyc,
                           output int first_a, output int first_b,
                           output int gap_viol, output int both, output int busy_cyc);
        int cyc;
        int last;
        na = 0; nb = 0; dcyc = -1; first_a = -1; first_b = -1;
        gap_viol = 0; both = 0; busy_cyc = 0; last = -1;
        start = 1'b1; amount = amt; prefer_dime = pd;
        tick();
        if (!spam) start = 1'b0;
        for (cyc = 1; cyc < 100; cyc++) begin
            if (busy) busy_cyc++;
            if (a) begin na++; if (first_a < 0) first_a = cyc; end
            if (b) begin nb++; if (first_b < 0) first_b = cyc; end
            if (a && b) both++;
            if (a || b) begin
                if (last >= 0 && (cyc - last) != 3) gap_viol++;
                last = cyc;
            end
            if (done) begin
                dcyc = cyc;
                break;
            end
            tick();
        end
        start = 1'b0;
        tick();
    endtask

    initial begin
        int na, nb, dcyc, fa, fb, gv, both, bc, stray;

        rst_n = 1'b0; start = 1'b0; amount = 4'd0; prefer_dime = 1'b0;
        clr_cnt = 1'b0; force_y0 = 1'b0;
        #3;
        check("rst_a",      a, 0);
        check("rst_b",      b, 0);
        check("rst_busy",   busy, 0);
        check("rst_done",   done, 0);
        check("rst_err",    err, 0);
        check("rst_prod",   prod_cnt, 0);
        check("rst_change", change_cnt, 0);
        #9 rst_n = 1'b1;
        tick();

        // 3 units, dimes preferred: dime (y=1) then nickel (00).
        run_req(4'd3, 1'b1, 1'b0, na, nb, dcyc, fa, fb, gv, both, bc);
        check("r3_first_b", fb, 1);
        check("r3_first_a", fa, 4);
        check("r3_nb",      nb, 1);
        check("r3_na",      na, 1);
        check("r3_done",    dcyc, 7);
        check("r3_both",    both, 0);
        check("r3_prod",    prod_cnt, 1);
        check("r3_change",  change_cnt, 0);
        check("r3_err",     err, 0);

        // 2 units on 5 cents credit: one dime, answered 11.
        run_req(4'd2, 1'b1, 1'b0, na, nb, dcyc, fa, fb, gv, both, bc);
        check("r2_nb",     nb, 1);
        check("r2_na",     na, 0);
        check("r2_done",   dcyc, 4);
        check("r2_prod",   prod_cnt, 2);
        check("r2_change", change_cnt, 1);
        check("r2_err",    err, 0);

        // Zero amount: no coins, busy for one cycle, done in cycle 1.
        run_req(4'd0, 1'b0, 1'b0, na, nb, dcyc, fa, fb, gv, both, bc);
        check("r0_coins",  na + nb, 0);
        check("r0_busy",   bc, 1);
        check("r0_done",   dcyc, 1);
        check("r0_prod",   prod_cnt, 2);
        check("r0_change", change_cnt, 1);

        // Wrong answer: y suppressed on a dime from zero credit.
        force_y0 = 1'b1;
        run_req(4'd2, 1'b1, 1'b0, na, nb, dcyc, fa, fb, gv, both, bc);
        force_y0 = 1'b0;
        check("bad_err",    err, 1);
        check("bad_prod",   prod_cnt, 2);
        check("bad_change", change_cnt, 1);

        // Correct nickel afterwards: err must stay set.
        run_req(4'd1, 1'b0, 1'b0, na, nb, dcyc, fa, fb, gv, both, bc);
        check("sticky_err", err, 1);
        check("sticky_na",  na, 1);

        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check("clr_err",    err, 0);
        check("clr_prod",   prod_cnt, 0);
        check("clr_change", change_cnt, 0);

        // Four nickels with start held high throughout (credit starts at 1):
        // answers 10, 00, 10, 00.
        run_req(4'd4, 1'b0, 1'b1, na, nb, dcyc, fa, fb, gv, both, bc);
        check("n4_na",      na, 4);
        check("n4_nb",      nb, 0);
        check("n4_gap",     gv, 0);
        check("n4_done",    dcyc, 13);
        check("n4_idle",    busy, 0);
        check("n4_nodone",  done, 0);
        check("n4_prod",    prod_cnt, 2);
        check("n4_change",  change_cnt, 0);
        check("n4_err",     err, 0);

        // Reset in the gap after the 2nd of 4 nickels.
        start = 1'b1; amount = 4'd4; prefer_dime = 1'b0;
        tick();
        start = 1'b0;
        check("pre_rst_a", a, 1);
        repeat (4) tick();
        check("pre_rst_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_a",      a, 0);
        check("mid_rst_b",      b, 0);
        check("mid_rst_busy",   busy, 0);
        check("mid_rst_done",   done, 0);
        check("mid_rst_prod",   prod_cnt, 0);
        #3 rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (a || b || busy || done) stray++;
        end
        check("post_rst_stray", stray, 0);

        // Shadow must be back at 0: a lone nickel is expected to answer 00.
        run_req(4'd1, 1'b0, 1'b0, na, nb, dcyc, fa, fb, gv, both, bc);
        check("post_rst_na",   na, 1);
        check("post_rst_done", dcyc, 4);
        check("post_rst_err",  err, 0);
        check("post_rst_prod", prod_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
